// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier accumulate/serialise path.
package booth_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        SEND  = 1'b1
    } state_t;

    localparam int PROD_W    = 16;
    localparam int OUT_BYTES = 3;
    localparam int SNAP_W    = 24;

endpackage

// File: rtl/booth_sat_add.sv
// Signed accumulator plus product with clamp to the accumulator range.
import booth_pkg::*;

module booth_sat_add #(
    parameter int ACC_W = 20
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [PROD_W-1:0] i_prod,
    output logic signed [ACC_W-1:0]  o_sum,
    output logic                     o_ovf
);

    localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

    // One guard bit is enough: the sum of an ACC_W and a narrower operand
    // always fits in ACC_W+1 bits.
    logic signed [ACC_W:0] w_wide;

    assign w_wide = (ACC_W+1)'(i_acc) + (ACC_W+1)'(i_prod);
    assign o_ovf  = w_wide[ACC_W] ^ w_wide[ACC_W-1];

    // Clamp toward the sign of the exact (wide) result.
    always_comb begin
        o_sum = w_wide[ACC_W-1:0];
        if (o_ovf) begin
            o_sum = w_wide[ACC_W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/booth_acc_serializer.sv
// Saturating multiply-accumulate stage with a three-byte LSB-first dump port.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | products accepted and summed; dump snapshots and starts SEND
// SEND  | snapshot presented byte by byte; products stalled, acc holds
import booth_pkg::*;

module booth_acc_serializer #(
    parameter int ACC_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              clear,
    input  logic              dump,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sat
);

    localparam logic [1:0] LAST_IDX = 2'(OUT_BYTES - 1);

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic [SNAP_W-1:0]         r_snap;
    logic                      r_sat;
    logic [1:0]                r_idx;
    logic [7:0]                r_out_byte;
    logic                      r_out_valid;
    logic                      r_out_last;
    logic                      r_prod_ready;

    logic signed [ACC_W-1:0]   w_sum;
    logic                      w_ovf;
    logic                      w_accept;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic                      w_sat_next;
    logic signed [SNAP_W-1:0]  w_snap_next;
    logic [1:0]                w_idx_inc;

    booth_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_acc  (r_acc),
        .i_prod (signed'(prod)),
        .o_sum  (w_sum),
        .o_ovf  (w_ovf)
    );

    // Post-accept view of the accumulator; the snapshot uses this so a product
    // arriving in the dump cycle is included.
    assign w_accept    = prod_valid && (r_state == ACCUM);
    assign w_acc_next  = w_accept ? w_sum : r_acc;
    assign w_sat_next  = r_sat | (w_accept & w_ovf);
    assign w_snap_next = SNAP_W'(w_acc_next);
    assign w_idx_inc   = r_idx + 2'd1;

    // Accumulator, snapshot and serial output sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ACCUM;
            r_acc        <= '0;
            r_snap       <= '0;
            r_sat        <= 1'b0;
            r_idx        <= 2'd0;
            r_out_byte   <= 8'h00;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_prod_ready <= 1'b1;
        end else begin
            case (r_state)
                ACCUM: begin
                    // clear wins over an accepted product
                    if (clear) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end else begin
                        r_acc <= w_acc_next;
                        r_sat <= w_sat_next;
                    end
                    if (dump) begin
                        r_snap       <= w_snap_next;
                        r_idx        <= 2'd0;
                        r_out_byte   <= w_snap_next[7:0];
                        r_out_valid  <= 1'b1;
                        r_out_last   <= (LAST_IDX == 2'd0);
                        r_prod_ready <= 1'b0;
                        r_state      <= SEND;
                    end
                end
                SEND: begin
                    if (clear) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end
                    if (out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_out_valid  <= 1'b0;
                            r_out_last   <= 1'b0;
                            r_out_byte   <= 8'h00;
                            r_prod_ready <= 1'b1;
                            r_state      <= ACCUM;
                        end else begin
                            r_idx      <= w_idx_inc;
                            r_out_byte <= r_snap[{w_idx_inc, 3'b000} +: 8];
                            r_out_last <= (w_idx_inc == LAST_IDX);
                        end
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign prod_ready = r_prod_ready;
    assign out_byte   = r_out_byte;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign sat        = r_sat;

endmodule

// File: tb/tb_booth_acc_serializer.sv
// Directed plus randomized bench for booth_acc_serializer against a plain
// integer model of the saturating accumulator.
module tb_booth_acc_serializer;

    localparam int  ACC_W = 20;
    localparam longint MAX_V = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint MIN_V = -(64'sd1 <<< (ACC_W-1));

    logic        clk;
    logic        rst_n;
    logic        prod_valid;
    logic        prod_ready;
    logic [15:0] prod;
    logic        clear;
    logic        dump;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        sat;

    int checks = 0;
    int errors = 0;

    longint m_acc = 0;
    bit     m_sat = 0;

    booth_acc_serializer #(
        .ACC_W (ACC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .clear      (clear),
        .dump       (dump),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .sat        (sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_add(input int p);
        longint s;
        s = m_acc + longint'(p);
        if (s > MAX_V) begin
            s = MAX_V;
            m_sat = 1'b1;
        end else if (s < MIN_V) begin
            s = MIN_V;
            m_sat = 1'b1;
        end
        m_acc = s;
    endfunction

    // One accepted product, optionally with clear in the same cycle.
    task automatic push(input int p, input bit clr);
        prod_valid = 1'b1;
        prod       = 16'(p);
        clear      = clr;
        @(negedge clk);
        prod_valid = 1'b0;
        clear      = 1'b0;
        if (clr) begin
            m_acc = 0;
            m_sat = 1'b0;
        end else begin
            model_add(p);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_acc = 0;
        m_sat = 1'b0;
        check("clear_sat", 32'(sat), 32'(m_sat));
    endtask

    // Dump, optionally with a product and/or clear in the same cycle, then
    // drain the three bytes, stalling `stall` cycles on byte 1.
    task automatic dump_check(input string tag, input bit with_prod, input int p,
                              input bit with_clear, input int stall);
        longint    snap;
        bit [23:0] s24;
        bit [7:0]  eb;
        dump       = 1'b1;
        clear      = with_clear;
        prod_valid = with_prod;
        prod       = 16'(p);
        @(negedge clk);
        dump       = 1'b0;
        clear      = 1'b0;
        prod_valid = 1'b0;
        if (with_prod) model_add(p);
        snap = m_acc;
        if (with_clear) begin
            m_acc = 0;
            m_sat = 1'b0;
        end
        s24 = 24'(snap);
        check({tag, "_sat"}, 32'(sat), 32'(m_sat));
        for (int i = 0; i < 3; i++) begin
            eb = s24[8*i +: 8];
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_byte"}, 32'(out_byte), 32'(eb));
            check({tag, "_last"}, 32'(out_last), 32'(i == 2));
            check({tag, "_pready"}, 32'(prod_ready), 32'd0);
            if (i == 1 && stall > 0) begin
                out_ready  = 1'b0;
                prod_valid = 1'b1;
                prod       = 16'($urandom_range(0, 65535));
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    check({tag, "_stall_byte"}, 32'(out_byte), 32'(eb));
                    check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                    check({tag, "_stall_pready"}, 32'(prod_ready), 32'd0);
                end
                prod_valid = 1'b0;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_last"}, 32'(out_last), 32'd0);
        check({tag, "_done_pready"}, 32'(prod_ready), 32'd1);
    endtask

    initial begin
        int op;
        int p;
        rst_n      = 1'b0;
        prod_valid = 1'b0;
        prod       = 16'h0000;
        clear      = 1'b0;
        dump       = 1'b0;
        out_ready  = 1'b0;

        // Reset values while held
        repeat (2) @(negedge clk);
        check("rst_byte", 32'(out_byte), 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_pready", 32'(prod_ready), 32'd1);
        check("rst_sat", 32'(sat), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_pready", 32'(prod_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Basic accumulate: 0x3F38
        push(100, 1'b0);
        push(-300, 1'b0);
        push(16384, 1'b0);
        dump_check("basic", 1'b0, 0, 1'b0, 0);
        check("basic_model", 32'(m_acc), 32'(16184));

        // Positive saturation then clear
        do_clear();
        for (int i = 0; i < 40; i++) push(16384, 1'b0);
        check("satpos_sat", 32'(sat), 32'd1);
        dump_check("satpos", 1'b0, 0, 1'b0, 0);
        do_clear();
        dump_check("after_clear", 1'b0, 0, 1'b0, 0);

        // Negative value 0xFFC080
        push(-16256, 1'b0);
        dump_check("neg", 1'b0, 0, 1'b0, 0);

        // Backpressure on byte 1 with products offered; acc must not move
        do_clear();
        push(100, 1'b0);
        push(-300, 1'b0);
        push(16384, 1'b0);
        dump_check("bp", 1'b0, 0, 1'b0, 5);
        dump_check("bp_hold", 1'b0, 0, 1'b0, 0);

        // Read-and-clear with a product in the same cycle
        do_clear();
        push(10, 1'b0);
        dump_check("rdclr", 1'b1, 7, 1'b1, 0);
        dump_check("rdclr_after", 1'b0, 0, 1'b0, 0);

        // Clear with an accepted product discards it
        push(500, 1'b0);
        push(1234, 1'b1);
        dump_check("clr_prod", 1'b0, 0, 1'b0, 0);

        // Negative saturation
        for (int i = 0; i < 20; i++) push(-32768, 1'b0);
        check("satneg_sat", 32'(sat), 32'd1);
        dump_check("satneg", 1'b0, 0, 1'b0, 0);
        do_clear();

        // Randomized mix
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 19));
            p  = int'($urandom_range(0, 65535)) - 32768;
            if (op < 14) begin
                push(p, 1'b0);
                check("rnd_sat", 32'(sat), 32'(m_sat));
            end else if (op == 14) begin
                push(p, 1'b1);
            end else if (op == 15) begin
                @(negedge clk);
            end else begin
                dump_check("rnd_dump", bit'($urandom_range(0, 1)), p,
                           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
            end
        end

        // Reset asserted while byte 1 is on the pins
        do_clear();
        push(4660, 1'b0);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rst_mid_byte1", 32'(out_byte), 32'h12);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0;
        m_sat = 1'b0;
        @(negedge clk);
        check("rst_mid_pready", 32'(prod_ready), 32'd1);
        check("rst_mid_outv", 32'(out_valid), 32'd0);
        dump_check("rst_mid_after", 1'b0, 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
